apb_reg_slave: RTL and testbench
================================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data bus width; legal values are 8, 16 and 32.
REQ-002 Parameter ADDR_W, default 6, SHALL set the byte-address width.
REQ-003 Parameter NUM_REGS, default 8, SHALL set the number of word registers; NUM_REGS <= 2^(ADDR_W-log2(DATA_W/8)).
REQ-004 Parameter WAIT_CYC, default 2, SHALL set the wait states inserted per access; legal range is 0..7.
REQ-005 Parameter RO_MASK, default NUM_REGS'b1, SHALL mark read-only registers, one bit per register index.
REQ-006 pclk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 paddr  in  ADDR_W  SHALL be the byte address; the register index is paddr[ADDR_W-1:log2(DATA_W/8)].
REQ-009 psel, penable, pwrite  in  1 each  SHALL carry the standard APB select, enable and direction.
REQ-010 pwdata  in  DATA_W  SHALL carry write data.
REQ-011 pstrb  in  DATA_W/8  SHALL be the per-byte write strobe.
REQ-012 prdata  out  DATA_W  SHALL carry read data.
REQ-013 pready  out  1  SHALL be the transfer-complete indication.
REQ-014 pslverr  out  1  SHALL be the error response.

Function
REQ-015 Phases: SETUP = psel & !penable; ACCESS = psel & penable; IDLE = !psel.
REQ-016 The wait counter SHALL load WAIT_CYC in IDLE and in SETUP, and SHALL decrement once per ACCESS cycle while nonzero.
REQ-017 pready SHALL be 1 outside ACCESS and (wait counter == 0) inside ACCESS, so every access lasts exactly WAIT_CYC+1 ACCESS cycles.
REQ-018 The completion cycle is ACCESS & pready; all side effects SHALL occur only on its rising edge, exactly once per transfer.
REQ-019 An error SHALL be flagged if the register index >= NUM_REGS, or if a write targets an index with RO_MASK set.
REQ-020 pslverr SHALL equal the error flag in the completion cycle and be 0 in all other cycles.
REQ-021 On a write completion without error, each byte i with pstrb[i]=1 SHALL take pwdata byte i; bytes with pstrb[i]=0 SHALL be unchanged.
REQ-022 On a write completion with error, no register SHALL change.
REQ-023 prdata SHALL equal the addressed register in a read completion cycle without error, and SHALL be 0 in every other cycle.
REQ-024 Register 0 SHALL be a read-only read counter, reset to 55 and incremented by 1 (mod 2^DATA_W) on the edge ending each error-free read completion of any index.
REQ-025 The cycle that returns register 0 SHALL return the pre-increment value.
REQ-026 If psel drops during ACCESS before completion, the transfer SHALL be abandoned: no side effects, counter reloaded.
REQ-027 Back-to-back transfers (SETUP immediately after a completion) SHALL incur the full WAIT_CYC again.

Reset
REQ-028 While rst_n=0, asynchronously: counter = WAIT_CYC, register 0 = 55, all other registers = 0, pready = 1, pslverr = 0, prdata = 0.
REQ-029 Reset asserted mid-ACCESS SHALL abort the transfer with no register update; after release, operation restarts from IDLE.

Structure
REQ-030 Shared package apb_pkg SHALL hold the phase enum (IDLE/SETUP/ACCESS), the register-0 reset constant (55) and the default parameter values.
REQ-031 The wait-state logic SHALL be a sub-module apb_wait_ctr (parameter WAIT_CYC; ports pclk, rst_n, phase in, pready out).

Verification
REQ-032 Bench SHALL check, with WAIT_CYC=2: write 0xA5A5A5A5 to addr 0x04, pstrb=4'hF -> pready low 2 ACCESS cycles, high on the 3rd; pslverr=0; a subsequent read of 0x04 returns 0xA5A5A5A5.
REQ-033 Bench SHALL check: write 0x11223344 to addr 0x08 with pstrb=4'b0101 over a register holding 0 -> read returns 0x00220044.
REQ-034 Bench SHALL check: three successive reads of addr 0x00 after reset -> 55, 56, 57; a write to 0x00 -> pslverr=1 and the next read returns 58.
REQ-035 Bench SHALL check: read of addr 0x20 (index 8 with NUM_REGS=8) -> pslverr=1, prdata=0, no counter increment.
REQ-036 Bench SHALL check: rst_n pulsed low during the 2nd ACCESS cycle of a write to 0x0C -> register 0x0C reads 0 and register 0 reads 55.
REQ-037 Bench SHALL check: WAIT_CYC=0 build -> pready=1 in the first ACCESS cycle and back-to-back transfers complete every 2 cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB register slave and its wait-state counter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_WAIT_CYC = 2;
    localparam int REG0_RST     = 55;

    function automatic phase_e decode_phase(input logic psel, input logic penable);
        phase_e ph;
        if (!psel) begin
            ph = IDLE;
        end else if (!penable) begin
            ph = SETUP;
        end else begin
            ph = ACCESS;
        end
        return ph;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a master and the register slave.
interface apb_reg_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: holds pready low for WAIT_CYC ACCESS cycles of every transfer.
module apb_wait_ctr
    import apb_pkg::*;
#(
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic   pclk,
    input  logic   rst_n,
    input  phase_e phase,
    output logic   pready
);

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC);

    logic [2:0] cnt_r;

    // reload outside ACCESS so an abandoned or back-to-back transfer starts afresh
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= WAIT_LD;
        end else if (phase != ACCESS) begin
            cnt_r <= WAIT_LD;
        end else if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // ready is forced high while reset is held
    always_comb begin
        pready = 1'b1;
        case (phase)
            ACCESS:  pready = (cnt_r == 3'd0) || !rst_n;
            default: pready = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: strobed word registers, read-only read counter at index 0,
// configurable wait states and error response for bad index or read-only writes.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                  DATA_W   = DEF_DATA_W,
    parameter int                  ADDR_W   = DEF_ADDR_W,
    parameter int                  NUM_REGS = DEF_NUM_REGS,
    parameter int                  WAIT_CYC = DEF_WAIT_CYC,
    parameter logic [NUM_REGS-1:0] RO_MASK  = NUM_REGS'(1)
) (
    input  logic             pclk,
    input  logic             rst_n,
    apb_reg_slave_if.slave   bus
);

    localparam int NBYTES  = DATA_W / 8;
    localparam int IDX_LSB = $clog2(NBYTES);
    localparam int IDX_W   = ADDR_W - IDX_LSB;
    localparam logic [DATA_W-1:0] REG0_INIT = DATA_W'(REG0_RST);

    phase_e              phase_s;
    logic                pready_s;
    logic                complete_s;
    logic                err_s;
    logic                wr_en_s;
    logic                rd_ok_s;
    logic [IDX_W-1:0]    idx_s;
    logic [NUM_REGS-1:0] sel_s;
    logic [DATA_W-1:0]   rdata_s;
    logic                unused_addr_s;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NBYTES-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < NBYTES; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign phase_s       = decode_phase(bus.psel, bus.penable);
    assign unused_addr_s = ^bus.paddr;

    apb_wait_ctr #(
        .WAIT_CYC (WAIT_CYC)
    ) u_wait_ctr (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .phase  (phase_s),
        .pready (pready_s)
    );

    // index decode, error detection, read mux and completion qualifiers
    always_comb begin
        idx_s   = bus.paddr[ADDR_W-1:IDX_LSB];
        sel_s   = {NUM_REGS{1'b0}};
        rdata_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_s == IDX_W'(i)) begin
                sel_s[i] = 1'b1;
                rdata_s  = regs_r[i];
            end else begin
                sel_s[i] = 1'b0;
            end
        end
        err_s      = (sel_s == {NUM_REGS{1'b0}}) ||
                     (bus.pwrite && ((sel_s & RO_MASK) != {NUM_REGS{1'b0}}));
        complete_s = rst_n && (phase_s == ACCESS) && pready_s;
        wr_en_s    = complete_s && bus.pwrite && !err_s;
        rd_ok_s    = complete_s && !bus.pwrite && !err_s;
    end

    assign bus.pready  = pready_s;
    assign bus.pslverr = complete_s && err_s;
    assign bus.prdata  = rd_ok_s ? rdata_s : {DATA_W{1'b0}};

    // register 0 counts error-free reads (returning the old value); others take strobed writes
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r[0] <= REG0_INIT;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (rd_ok_s) begin
                regs_r[0] <= regs_r[0] + DATA_W'(1);
            end else begin
                regs_r[0] <= regs_r[0];
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en_s && sel_s[i]) begin
                    regs_r[i] <= merge_bytes(regs_r[i], bus.pwdata, bus.pstrb);
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance.
module tb_apb_reg_slave;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] data;
        int          waits;
        int          gap;
    } exp_t;

    logic        pclk;
    logic        rst_a, rst_b;
    logic        sel_b;
    logic [5:0]  drv_addr;
    logic        drv_psel, drv_penable, drv_pwrite;
    logic [31:0] drv_wdata;
    logic [3:0]  drv_strb;

    int   errors   = 0;
    int   checks   = 0;
    int   idle_bad = 0;
    int   cyc      = 0;
    int   wa = 0, wb = 0;
    int   last_a = 0, last_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    apb_reg_slave_if #(.ADDR_W(6), .DATA_W(32)) ifa ();
    apb_reg_slave_if #(.ADDR_W(6), .DATA_W(32)) ifb ();

    apb_reg_slave #(.WAIT_CYC(2)) dut_a (.pclk(pclk), .rst_n(rst_a), .bus(ifa));
    apb_reg_slave #(.WAIT_CYC(0)) dut_b (.pclk(pclk), .rst_n(rst_b), .bus(ifb));

    assign ifa.paddr   = drv_addr;
    assign ifa.psel    = drv_psel & ~sel_b;
    assign ifa.penable = drv_penable;
    assign ifa.pwrite  = drv_pwrite;
    assign ifa.pwdata  = drv_wdata;
    assign ifa.pstrb   = drv_strb;
    assign ifb.paddr   = drv_addr;
    assign ifb.psel    = drv_psel & sel_b;
    assign ifb.penable = drv_penable;
    assign ifb.pwrite  = drv_pwrite;
    assign ifb.pwdata  = drv_wdata;
    assign ifb.pstrb   = drv_strb;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (xfer %0d): got 0x%08h expected 0x%08h", nm, id, act, exp);
        end
    endtask

    // monitor for the WAIT_CYC=2 instance
    always @(negedge pclk) begin : mon_a
        exp_t e;
        if (rst_a && ifa.psel && ifa.penable && ifa.pready) begin
            if (qa.size() == 0) begin
                chk("A.unexpected", -1, 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("A.pslverr", e.id, 32'(ifa.pslverr), 32'(e.err));
                chk("A.prdata",  e.id, ifa.prdata, e.data);
                chk("A.waits",   e.id, 32'(wa), 32'(e.waits));
            end
            wa     = 0;
            last_a = cyc;
        end else begin
            if (ifa.psel && ifa.penable) wa++;
            else wa = 0;
            if (ifa.prdata != 32'd0 || ifa.pslverr) idle_bad++;
            if (!(ifa.psel && ifa.penable) && !ifa.pready) idle_bad++;
            if (!rst_a && !ifa.pready) idle_bad++;
        end
    end

    // monitor for the WAIT_CYC=0 instance
    always @(negedge pclk) begin : mon_b
        exp_t e;
        if (rst_b && ifb.psel && ifb.penable && ifb.pready) begin
            if (qb.size() == 0) begin
                chk("B.unexpected", -1, 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("B.pslverr", e.id, 32'(ifb.pslverr), 32'(e.err));
                chk("B.prdata",  e.id, ifb.prdata, e.data);
                chk("B.waits",   e.id, 32'(wb), 32'(e.waits));
                if (e.gap != 0) chk("B.gap", e.id, 32'(cyc - last_b), 32'(e.gap));
            end
            wb     = 0;
            last_b = cyc;
        end else begin
            if (ifb.psel && ifb.penable) wb++;
            else wb = 0;
            if (ifb.prdata != 32'd0 || ifb.pslverr) idle_bad++;
            if (!(ifb.psel && ifb.penable) && !ifb.pready) idle_bad++;
        end
    end

    // one complete transfer; called at posedge+1, returns at posedge+1 after completion
    task automatic xfer(input int id, input logic [5:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic wr, input logic err,
                        input logic [31:0] data, input int waits, input int gap);
        exp_t e;
        logic done;
        e.id = id; e.err = err; e.data = data; e.waits = waits; e.gap = gap;
        if (sel_b) qb.push_back(e);
        else qa.push_back(e);
        drv_addr = addr; drv_wdata = wdata; drv_strb = strb; drv_pwrite = wr;
        drv_psel = 1'b1; drv_penable = 1'b0;
        @(posedge pclk); #1;
        drv_penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (sel_b ? ifb.pready : ifa.pready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("timeout", id, 32'd0, 32'd1);
        @(posedge pclk); #1;
        drv_psel = 1'b0; drv_penable = 1'b0;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; sel_b = 1'b0;
        drv_addr = 6'd0; drv_wdata = 32'd0; drv_strb = 4'd0; drv_pwrite = 1'b0;
        drv_psel = 1'b1; drv_penable = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst.pready",  0, 32'(ifa.pready),  32'd1);
        chk("rst.pslverr", 0, 32'(ifa.pslverr), 32'd0);
        chk("rst.prdata",  0, ifa.prdata,       32'd0);
        @(posedge pclk); #1;
        drv_psel = 1'b0; drv_penable = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge pclk); #1;

        xfer(1,  6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd55,        2, 0);
        xfer(2,  6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd56,        2, 0);
        xfer(3,  6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd57,        2, 0);
        xfer(4,  6'h00, 32'hDEADBEEF,  4'hF, 1'b1, 1'b1, 32'd0,         2, 0);
        xfer(5,  6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd58,        2, 0);
        xfer(6,  6'h04, 32'hA5A5A5A5,  4'hF, 1'b1, 1'b0, 32'd0,         2, 0);
        xfer(7,  6'h04, 32'd0,         4'hF, 1'b0, 1'b0, 32'hA5A5A5A5,  2, 0);
        xfer(8,  6'h08, 32'h11223344,  4'h5, 1'b1, 1'b0, 32'd0,         2, 0);
        xfer(9,  6'h08, 32'd0,         4'hF, 1'b0, 1'b0, 32'h00220044,  2, 0);
        xfer(10, 6'h20, 32'd0,         4'hF, 1'b0, 1'b1, 32'd0,         2, 0);
        xfer(11, 6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd61,        2, 0);
        xfer(12, 6'h1C, 32'hCAFEF00D,  4'hC, 1'b1, 1'b0, 32'd0,         2, 0);
        xfer(13, 6'h1C, 32'd0,         4'hF, 1'b0, 1'b0, 32'hCAFE0000,  2, 0);

        // abandoned write: psel drops after one ACCESS cycle
        drv_addr = 6'h10; drv_wdata = 32'h0BADF00D; drv_strb = 4'hF; drv_pwrite = 1'b1;
        drv_psel = 1'b1; drv_penable = 1'b0;
        @(posedge pclk); #1; drv_penable = 1'b1;
        @(posedge pclk); #1; drv_psel = 1'b0; drv_penable = 1'b0;
        @(posedge pclk); #1;
        xfer(14, 6'h10, 32'd0,         4'hF, 1'b0, 1'b0, 32'd0,         2, 0);
        xfer(15, 6'h3C, 32'h12345678,  4'hF, 1'b1, 1'b1, 32'd0,         2, 0);
        xfer(16, 6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd64,        2, 0);

        // reset pulse in the 2nd ACCESS cycle of a write to 0x0C
        drv_addr = 6'h0C; drv_wdata = 32'h12345678; drv_strb = 4'hF; drv_pwrite = 1'b1;
        drv_psel = 1'b1; drv_penable = 1'b0;
        @(posedge pclk); #1; drv_penable = 1'b1;
        @(posedge pclk); #1; rst_a = 1'b0;
        #2 rst_a = 1'b1;
        @(posedge pclk); #1; drv_psel = 1'b0; drv_penable = 1'b0;
        @(posedge pclk); #1;
        xfer(17, 6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd55,        2, 0);
        xfer(18, 6'h0C, 32'd0,         4'hF, 1'b0, 1'b0, 32'd0,         2, 0);

        // zero-wait instance, back-to-back
        sel_b = 1'b1;
        @(posedge pclk); #1;
        xfer(21, 6'h04, 32'h0000BEEF,  4'hF, 1'b1, 1'b0, 32'd0,         0, 0);
        xfer(22, 6'h04, 32'd0,         4'hF, 1'b0, 1'b0, 32'h0000BEEF,  0, 2);
        xfer(23, 6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd56,        0, 2);
        xfer(24, 6'h24, 32'd0,         4'hF, 1'b0, 1'b1, 32'd0,         0, 2);
        xfer(25, 6'h00, 32'd0,         4'hF, 1'b0, 1'b0, 32'd57,        0, 2);

        repeat (3) @(posedge pclk);
        chk("A.pending",  0, 32'(qa.size()), 32'd0);
        chk("B.pending",  0, 32'(qb.size()), 32'd0);
        chk("idle.outputs", 0, 32'(idle_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
